// File: rtl/qei_pkg.sv
// qei_pkg: shared definitions for the quadrature sample controller.
//   - main_state_t : homing FSM states (RUN, HOMING, CLEAR)
//   - TX_IDX_*     : byte positions inside an outgoing sample frame
//   - FRAME_LEN_BASE / FRAME_LEN : frame length without / with checksum
//   - ST_*_BIT     : bit positions inside the status byte (B0)
//   - make_status  : assembles the status byte
// Build option: QEI_SAMPLE_CTRL_CKSUM_EN appends an XOR checksum byte B5.
package qei_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOMING = 2'd1,
      ST_CLEAR  = 2'd2
   } main_state_t;

   localparam int FRAME_LEN_BASE = 5;

`ifdef QEI_SAMPLE_CTRL_CKSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
   localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

   localparam logic [2:0] TX_IDX_STATUS   = 3'd0;
   localparam logic [2:0] TX_IDX_SNAP_LO  = 3'd1;
   localparam logic [2:0] TX_IDX_SNAP_HI  = 3'd2;
   localparam logic [2:0] TX_IDX_DELTA_LO = 3'd3;
   localparam logic [2:0] TX_IDX_DELTA_HI = 3'd4;
   localparam logic [2:0] TX_IDX_CKSUM    = 3'd5;
   localparam logic [2:0] TX_IDX_LAST     = 3'(FRAME_LEN - 1);

   localparam int ST_DIR_BIT   = 7;
   localparam int ST_HOMED_BIT = 6;
   localparam int ST_OVR_BIT   = 5;

   function automatic logic [7:0] make_status(input logic dir,
                                              input logic homed,
                                              input logic ovr);
      logic [7:0] s;
      s               = 8'h00;
      s[ST_DIR_BIT]   = dir;
      s[ST_HOMED_BIT] = homed;
      s[ST_OVR_BIT]   = ovr;
      return s;
   endfunction

endpackage

// File: rtl/qei_frame_tx.sv
// qei_frame_tx: latches one sample (status, snap, delta) and streams it as a
// byte frame B0 status, B1/B2 snap lo/hi, B3/B4 delta lo/hi
// (plus B5 = XOR of B0..B4 when QEI_SAMPLE_CTRL_CKSUM_EN is defined).
//
// Handshake: byte_o/byte_valid_o/byte_last_o are registers that change only
// on load or on a transfer (valid && ready), so they are stable while the
// consumer stalls; after a transfer the next byte appears the following cycle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load_i              capture status_i/snap_i/delta_i and start a frame
//                       (ignored while a frame is in flight)
//   status_i, snap_i, delta_i  frame contents
//   busy_o              a frame is in flight
//   done_o              final byte transfers this cycle
//   ovr_reported_o      in-flight frame's status byte carries the overrun flag
//   byte_o, byte_valid_o, byte_last_o, byte_ready_i  byte stream
module qei_frame_tx
   import qei_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [7:0]  status_i,
   input  logic [15:0] snap_i,
   input  logic [15:0] delta_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        ovr_reported_o,
   output logic [7:0]  byte_o,
   output logic        byte_valid_o,
   output logic        byte_last_o,
   input  logic        byte_ready_i
);

   logic [7:0]  status_q;
   logic [15:0] snap_q;
   logic [15:0] delta_q;
   logic [2:0]  idx_q;
   logic [2:0]  nxt_idx;
   logic [7:0]  nxt_byte;
   logic        xfer;

`ifdef QEI_SAMPLE_CTRL_CKSUM_EN
   logic [7:0]  cksum;
   assign cksum = status_q ^ snap_q[7:0] ^ snap_q[15:8] ^ delta_q[7:0] ^ delta_q[15:8];
`endif

   assign xfer           = byte_valid_o & byte_ready_i;
   assign busy_o         = byte_valid_o;
   assign done_o         = xfer & byte_last_o;
   assign ovr_reported_o = status_q[ST_OVR_BIT];
   assign nxt_idx        = idx_q + 3'd1;

   always_comb begin
      nxt_byte = 8'h00;
      case (nxt_idx)
         TX_IDX_SNAP_LO:  nxt_byte = snap_q[7:0];
         TX_IDX_SNAP_HI:  nxt_byte = snap_q[15:8];
         TX_IDX_DELTA_LO: nxt_byte = delta_q[7:0];
         TX_IDX_DELTA_HI: nxt_byte = delta_q[15:8];
`ifdef QEI_SAMPLE_CTRL_CKSUM_EN
         TX_IDX_CKSUM:    nxt_byte = cksum;
`endif
         default:         nxt_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q     <= 8'h00;
         snap_q       <= 16'h0000;
         delta_q      <= 16'h0000;
         idx_q        <= TX_IDX_STATUS;
         byte_o       <= 8'h00;
         byte_valid_o <= 1'b0;
         byte_last_o  <= 1'b0;
      end else if (load_i && !byte_valid_o) begin
         status_q     <= status_i;
         snap_q       <= snap_i;
         delta_q      <= delta_i;
         idx_q        <= TX_IDX_STATUS;
         byte_o       <= status_i;
         byte_valid_o <= 1'b1;
         byte_last_o  <= 1'b0;
      end else if (xfer) begin
         if (byte_last_o) begin
            byte_valid_o <= 1'b0;
            byte_last_o  <= 1'b0;
         end else begin
            idx_q       <= nxt_idx;
            byte_o      <= nxt_byte;
            byte_last_o <= (nxt_idx == TX_IDX_LAST);
         end
      end
   end

endmodule

// File: rtl/qei_sample_ctrl.sv
// qei_sample_ctrl: sequencing controller for the quadrature counter datapath.
//   - Homing FSM (RUN -> HOMING -> CLEAR -> RUN): waits for the index rising
//     edge, then pulses cnt_clr_o for one cycle; times out after
//     2^HOME_TO_W-1 cycles in HOMING and flags home_fail_o.
//   - Period counter: tick every period_i cycles (period_i==0 disables).
//   - On tick, snapshots cnt_i, computes delta against the previous snapshot
//     and hands the sample to qei_frame_tx for byte streaming.
// Build option: QEI_SAMPLE_CTRL_CKSUM_EN (checksum byte, inside qei_frame_tx).
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   cnt_i, dir_i     counter value and last-step direction from datapath
//   idx_i            synchronized encoder index
//   home_req_i       single-cycle homing request
//   period_i         sample period in cycles (0 = off)
//   cnt_en_o         counter enable
//   cnt_clr_o        one-cycle counter clear
//   homed_o          homing completed since last request
//   home_fail_o      sticky: last homing timed out
//   byte_o, byte_valid_o, byte_ready_i, byte_last_o  frame byte stream
//   overrun_o        sticky: a sample was dropped while a frame was in flight
module qei_sample_ctrl
   import qei_pkg::*;
#(
   parameter int PERIOD_W  = 16,
   parameter int HOME_TO_W = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         cnt_i,
   input  logic                dir_i,
   input  logic                idx_i,
   input  logic                home_req_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                cnt_en_o,
   output logic                cnt_clr_o,
   output logic                homed_o,
   output logic                home_fail_o,
   output logic [7:0]          byte_o,
   output logic                byte_valid_o,
   input  logic                byte_ready_i,
   output logic                byte_last_o,
   output logic                overrun_o
);

   localparam logic [PERIOD_W-1:0]  PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
   localparam logic [HOME_TO_W-1:0] TO_ONE     = {{(HOME_TO_W-1){1'b0}}, 1'b1};
   // Counter value one step before all-ones: the step that reaches all-ones
   // ends the homing attempt, so HOMING lasts 2^HOME_TO_W-1 cycles.
   localparam logic [HOME_TO_W-1:0] TO_LAST    = {{(HOME_TO_W-1){1'b1}}, 1'b0};

   main_state_t         state;
   logic [PERIOD_W-1:0] pcnt;
   logic [HOME_TO_W-1:0] to_cnt;
   logic [15:0]         prev_snap;
   logic                idx_q;

   logic                period_hit;
   logic                tick;
   logic                sample;
   logic                drop;
   logic                idx_rise;
   logic [15:0]         delta;
   logic [7:0]          status;
   logic                tx_busy;
   logic                tx_done;
   logic                tx_ovr_rep;

   assign period_hit = (period_i != '0) && (pcnt == (period_i - PERIOD_ONE));
   assign tick       = (state == ST_RUN) && period_hit;
   // A homing request in the tick cycle wins: the sample is neither taken nor
   // counted as an overrun.
   assign sample     = tick && !home_req_i && !tx_busy;
   assign drop       = tick && !home_req_i && tx_busy;
   assign idx_rise   = idx_i & ~idx_q;
   assign delta      = cnt_i - prev_snap;
   assign status     = make_status(dir_i, homed_o, overrun_o);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         pcnt        <= '0;
         to_cnt      <= '0;
         prev_snap   <= 16'h0000;
         idx_q       <= 1'b0;
         cnt_en_o    <= 1'b1;
         cnt_clr_o   <= 1'b0;
         homed_o     <= 1'b0;
         home_fail_o <= 1'b0;
      end else begin
         idx_q     <= idx_i;
         cnt_en_o  <= 1'b1;
         cnt_clr_o <= 1'b0;
         case (state)
            ST_RUN: begin
               if (home_req_i) begin
                  state       <= ST_HOMING;
                  homed_o     <= 1'b0;
                  home_fail_o <= 1'b0;
                  pcnt        <= '0;
                  to_cnt      <= '0;
               end else begin
                  if (period_i == '0 || period_hit) begin
                     pcnt <= '0;
                  end else begin
                     pcnt <= pcnt + PERIOD_ONE;
                  end
                  // Dropped samples leave prev_snap alone so the next delta
                  // spans every period since the last sent sample.
                  if (sample) begin
                     prev_snap <= cnt_i;
                  end
               end
            end
            ST_HOMING: begin
               pcnt <= '0;
               if (idx_rise) begin
                  state     <= ST_CLEAR;
                  cnt_clr_o <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
                  if (to_cnt == TO_LAST) begin
                     state       <= ST_RUN;
                     home_fail_o <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               // The counter is zeroed this cycle, so the next delta is
               // measured from zero.
               prev_snap <= 16'h0000;
               homed_o   <= 1'b1;
               state     <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

   // Cleared only by completion of a frame that reported it; a fresh drop in
   // that same cycle takes priority and keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_o <= 1'b0;
      end else if (drop) begin
         overrun_o <= 1'b1;
      end else if (tx_done && tx_ovr_rep) begin
         overrun_o <= 1'b0;
      end
   end

   qei_frame_tx u_frame_tx (
      .clk            (clk),
      .rst_n          (rst_n),
      .load_i         (sample),
      .status_i       (status),
      .snap_i         (cnt_i),
      .delta_i        (delta),
      .busy_o         (tx_busy),
      .done_o         (tx_done),
      .ovr_reported_o (tx_ovr_rep),
      .byte_o         (byte_o),
      .byte_valid_o   (byte_valid_o),
      .byte_last_o    (byte_last_o),
      .byte_ready_i   (byte_ready_i)
   );

endmodule

// File: tb/tb_qei_sample_ctrl.sv
`timescale 1ns/1ps
module tb_qei_sample_ctrl;

   localparam int HOME_TO_W = 4;
`ifdef QEI_SAMPLE_CTRL_CKSUM_EN
   localparam int TB_FRAME_LEN = 6;
`else
   localparam int TB_FRAME_LEN = 5;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] cnt_i;
   logic        dir_i;
   logic        idx_i;
   logic        home_req_i;
   logic [15:0] period_i;
   logic        cnt_en_o;
   logic        cnt_clr_o;
   logic        homed_o;
   logic        home_fail_o;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i;
   logic        byte_last_o;
   logic        overrun_o;

   qei_sample_ctrl #(.PERIOD_W(16), .HOME_TO_W(HOME_TO_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cnt_i        (cnt_i),
      .dir_i        (dir_i),
      .idx_i        (idx_i),
      .home_req_i   (home_req_i),
      .period_i     (period_i),
      .cnt_en_o     (cnt_en_o),
      .cnt_clr_o    (cnt_clr_o),
      .homed_o      (homed_o),
      .home_fail_o  (home_fail_o),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .byte_last_o  (byte_last_o),
      .overrun_o    (overrun_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [8:0] exp_q[$];   // {last, byte}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] st, input logic [15:0] sn, input logic [15:0] dl);
      logic [7:0] b[6];
      b[0] = st;
      b[1] = sn[7:0];
      b[2] = sn[15:8];
      b[3] = dl[7:0];
      b[4] = dl[15:8];
      b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
      for (int i = 0; i < TB_FRAME_LEN; i++) begin
         exp_q.push_back({(i == TB_FRAME_LEN - 1), b[i]});
      end
   endtask

   // Output monitor, sampled on the falling edge.
   logic       stall_seen;
   logic [8:0] stall_val;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("hold_valid", 32'(byte_valid_o), 32'd1);
            check("hold_byte", 32'({byte_last_o, byte_o}), 32'(stall_val));
         end
         if (byte_valid_o && byte_ready_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h want none", {byte_last_o, byte_o});
            end else begin
               check("frame_byte", 32'({byte_last_o, byte_o}), 32'(exp_q.pop_front()));
            end
         end
         stall_seen = byte_valid_o && !byte_ready_i;
         stall_val  = {byte_last_o, byte_o};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!byte_valid_o && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!byte_valid_o) begin
         total++;
         bad++;
         $display("FAIL frame_start: got no valid want valid within %0d", budget);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || byte_valid_o) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Start sampling at period p from a held counter, stop after one tick.
   task automatic run_frame(input logic [15:0] c, input logic d, input logic [15:0] p,
                            input logic [7:0] st, input logic [15:0] dl);
      int n;
      step();
      cnt_i    = c;
      dir_i    = d;
      push_frame(st, c, dl);
      period_i = p;
      wait_valid(64, n);
      check("tick_latency", 32'(n), 32'(p) + 32'd1);
      step();
      period_i = 16'd0;
      drain(200);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [15:0] cnt;
      logic        dir;
      logic [15:0] period;
      logic [7:0]  exp_status;
      logic [15:0] exp_delta;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int n;
      int clr_cnt;
      int valid_cnt;

      tbl[0] = '{16'h0010, 1'b0, 16'd4, 8'h00, 16'h0010};
      tbl[1] = '{16'h0013, 1'b1, 16'd5, 8'h80, 16'h0003};
      tbl[2] = '{16'hFFFE, 1'b0, 16'd3, 8'h00, 16'hFFEB};
      tbl[3] = '{16'h0001, 1'b1, 16'd6, 8'h80, 16'h0003};
      tbl[4] = '{16'hFFFE, 1'b0, 16'd4, 8'h00, 16'hFFFD};
      tbl[5] = '{16'h1234, 1'b1, 16'd9, 8'h80, 16'h1236};

      rst_n        = 1'b0;
      cnt_i        = 16'h0000;
      dir_i        = 1'b0;
      idx_i        = 1'b0;
      home_req_i   = 1'b0;
      period_i     = 16'd0;
      byte_ready_i = 1'b1;
      #23;
      check("rst_cnt_en", 32'(cnt_en_o), 32'd1);
      check("rst_cnt_clr", 32'(cnt_clr_o), 32'd0);
      check("rst_homed", 32'(homed_o), 32'd0);
      check("rst_home_fail", 32'(home_fail_o), 32'd0);
      check("rst_byte", 32'(byte_o), 32'd0);
      check("rst_valid", 32'(byte_valid_o), 32'd0);
      check("rst_last", 32'(byte_last_o), 32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      step();
      rst_n = 1'b1;

      // Table: plain sampling, delta wrap in both directions.
      for (int i = 0; i < 6; i++) begin
         run_frame(tbl[i].cnt, tbl[i].dir, tbl[i].period, tbl[i].exp_status, tbl[i].exp_delta);
         check("tbl_overrun", 32'(overrun_o), 32'd0);
      end

      // Homing with index 10 cycles after the request.
      step();
      home_req_i = 1'b1;
      step();
      home_req_i = 1'b0;
      repeat (9) begin
         check("homing_homed_low", 32'(homed_o), 32'd0);
         check("homing_no_clr", 32'(cnt_clr_o), 32'd0);
         step();
      end
      idx_i = 1'b1;
      step();
      check("clr_pulse", 32'(cnt_clr_o), 32'd1);
      check("clr_homed_low", 32'(homed_o), 32'd0);
      clr_cnt = 1;
      for (int k = 0; k < 7; k++) begin
         step();
         if (cnt_clr_o) clr_cnt++;
      end
      idx_i = 1'b0;
      check("clr_pulse_count", 32'(clr_cnt), 32'd1);
      check("homed_set", 32'(homed_o), 32'd1);
      check("homed_no_fail", 32'(home_fail_o), 32'd0);
      run_frame(16'h0005, 1'b1, 16'd4, 8'hC0, 16'h0005);

      // Homing timeout without index.
      step();
      home_req_i = 1'b1;
      step();
      home_req_i = 1'b0;
      check("to_homed_cleared", 32'(homed_o), 32'd0);
      n = 0;
      while (!home_fail_o && n < 40) begin
         step();
         n++;
      end
      check("to_cycles", 32'(n), 32'd15);
      check("to_fail", 32'(home_fail_o), 32'd1);
      check("to_homed", 32'(homed_o), 32'd0);
      run_frame(16'h0009, 1'b0, 16'd4, 8'h00, 16'h0004);
      check("to_fail_sticky", 32'(home_fail_o), 32'd1);

      // Overrun: stall the consumer while ticks keep arriving.
      step();
      byte_ready_i = 1'b0;
      cnt_i        = 16'h0100;
      dir_i        = 1'b0;
      push_frame(8'h00, 16'h0100, 16'h00F7);
      period_i     = 16'd3;
      wait_valid(64, n);
      repeat (12) step();
      check("ovr_set", 32'(overrun_o), 32'd1);
      check("ovr_valid_held", 32'(byte_valid_o), 32'd1);
      period_i = 16'd0;
      step();
      byte_ready_i = 1'b1;
      drain(200);
      check("ovr_kept", 32'(overrun_o), 32'd1);
      run_frame(16'h0180, 1'b0, 16'd4, 8'h20, 16'h0080);
      check("ovr_cleared", 32'(overrun_o), 32'd0);

      // Mid-frame asynchronous reset.
      step();
      byte_ready_i = 1'b0;
      cnt_i        = 16'h0200;
      period_i     = 16'd3;
      wait_valid(64, n);
      step();
      period_i = 16'd0;
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(byte_valid_o), 32'd0);
      check("arst_last", 32'(byte_last_o), 32'd0);
      exp_q.delete();
      byte_ready_i = 1'b1;

      // Homing request coincident with a tick.
      cnt_i = 16'h0030;
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      period_i = 16'd4;
      repeat (3) step();
      home_req_i = 1'b1;
      step();
      home_req_i = 1'b0;
      period_i   = 16'd0;
      valid_cnt  = 0;
      for (int k = 0; k < 20; k++) begin
         if (byte_valid_o) valid_cnt++;
         step();
      end
      check("coinc_no_frame", 32'(valid_cnt), 32'd0);
      check("coinc_overrun", 32'(overrun_o), 32'd0);
      check("coinc_fail", 32'(home_fail_o), 32'd1);
      run_frame(16'h0042, 1'b0, 16'd5, 8'h00, 16'h0042);

      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/qei_sample_ctrl.md
Name: qei_sample_ctrl

Overview:
Controller that sequences the quadrature counter datapath. It runs the homing sequence, which enables the counter, waits for the index pulse and issues a counter clear. It also schedules periodic samples of the count, computes the per-period delta (velocity), and streams each sample as a byte frame over a valid/ready handshake. It sits between the quadrature decoder/counter and the byte-wide pin or host interface.

Parameters:
PERIOD_W, 16, width of sample-period input period_i
HOME_TO_W, 20, width of homing timeout counter; timeout = 2^HOME_TO_W - 1 cycles

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cnt_i  in  16  counter value from decoder datapath
dir_i  in  1  last-step direction from datapath (1=forward)
idx_i  in  1  encoder index pulse, already synchronized to clk
home_req_i  in  1  single-cycle request to start homing
period_i  in  PERIOD_W  sample period in cycles; 0 = sampling disabled
cnt_en_o  out  1  counter enable to datapath
cnt_clr_o  out  1  one-cycle synchronous clear to counter
homed_o  out  1  homing completed since last request
home_fail_o  out  1  sticky: last homing timed out
byte_o  out  8  frame byte
byte_valid_o  out  1  byte_o valid
byte_ready_i  in  1  consumer accepts byte
byte_last_o  out  1  final byte of frame
overrun_o  out  1  sticky: sample dropped because a frame was in flight

Behaviour:
- Reset values: cnt_en_o=1, cnt_clr_o=0, homed_o=0, home_fail_o=0, byte_o=0, byte_valid_o=0, byte_last_o=0, overrun_o=0.
- Internal reset values: state=RUN, period counter=0, prev_snap=0, idx_q=0.
- Async reset mid-frame aborts the frame; byte_valid_o drops immediately.
- Main FSM states: RUN, HOMING, CLEAR.
- RUN: period counter counts 0..period_i-1 and wraps. tick is asserted in the cycle the counter equals period_i-1. If period_i==0, the counter is held at 0 and no tick occurs. A period_i change takes effect on the counter's next compare.
- RUN + home_req_i -> HOMING. On entry: homed_o<=0, home_fail_o<=0, period counter<=0, timeout counter<=0.
- HOMING: cnt_en_o=1; ticks suppressed; home_req_i ignored. Index rising edge (idx_i & ~idx_q) -> CLEAR. Timeout counter saturating at all-ones -> RUN with home_fail_o<=1.
- CLEAR: cnt_clr_o=1 for exactly one cycle; prev_snap<=0; homed_o<=1; -> RUN.
- Sampling on tick with TX idle:
  - snap<=cnt_i, delta<=cnt_i-prev_snap (16-bit modulo, two's complement), prev_snap<=cnt_i.
  - Latch dir_i, homed_o and overrun_o into the status byte.
  - Start frame; byte_valid_o rises in the cycle after the tick.
- Tick with TX busy: sample discarded, prev_snap unchanged (next delta spans both periods), overrun_o<=1.
- overrun_o clears when a frame whose status byte reported it completes; a new overrun in that same cycle keeps it set.
- Frame order:
  - B0 status {dir, homed, overrun, 5'b0}
  - B1 snap[7:0], B2 snap[15:8]
  - B3 delta[7:0], B4 delta[15:8]
  - byte_last_o is asserted on the final byte.
- Handshake: byte_o, byte_valid_o and byte_last_o stay stable while valid && !ready. A byte transfers when valid && ready; the next byte is presented on the following cycle, giving back-to-back bytes with ready held high.
- Simultaneous home_req_i and tick: homing wins, tick dropped, overrun unchanged.
- A frame already in flight when homing starts completes normally.

Optional Feature:
QEI_SAMPLE_CTRL_CKSUM_EN
- Defined: frame gains a sixth byte B5 = XOR of B0..B4; byte_last_o moves to B5.
- Undefined: frame is 5 bytes; no checksum logic is present.

Decomposition:
- Package qei_pkg holds:
  - main FSM state enum (RUN, HOMING, CLEAR)
  - TX byte-index constants
  - FRAME_LEN_BASE=5
  - status-byte bit positions
- One sub-module qei_frame_tx holds:
  - frame latch
  - byte sequencer with valid/ready
  - optional checksum
- The top module holds the homing FSM, period counter and delta arithmetic.

Test Plan:
- Reset, period_i=4, cnt_i=0x0010 then 0x0013, ready=1 → first frame 00 10 00 10 00 with ready=1 throughout.
- Homing:
  - home_req_i pulse, then idx_i rising 10 cycles later → homed_o low during HOMING, cnt_clr_o high for exactly 1 cycle, then homed_o=1.
  - The next frame's delta equals cnt_i relative to 0.
- Homing timeout with HOME_TO_W=4 and no index → home_fail_o=1 after 15 cycles, state RUN, homed_o=0.
- Overrun: period_i=3, byte_ready_i held low → overrun_o=1, byte_o stable. Release ready → status byte bit5=1; overrun_o clears after byte_last_o transfer.
- Delta wrap: prev snap 0xFFFE, cnt_i 0x0001 → delta bytes 03 00. Reverse direction 0x0001→0xFFFE → FD FF.
- Mid-frame reset, plus home_req_i coincident with tick → valid drops asynchronously; tick dropped, no frame, overrun unchanged. With QEI_SAMPLE_CTRL_CKSUM_EN, a 6th byte equals the XOR of B0..B4.
